// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard (set at issue, cleared at writeback).
// Optional same-cycle write forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NR_READ  = 2,
  parameter int NR_WRITE = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NR_READ*AW-1:0]    rd_addr_i,
  output logic [NR_READ*XLEN-1:0]  rd_data_o,
  output logic [NR_READ-1:0]       rd_busy_o,
  input  logic [NR_WRITE-1:0]      wr_en_i,
  input  logic [NR_WRITE*AW-1:0]   wr_addr_i,
  input  logic [NR_WRITE*XLEN-1:0] wr_data_i,
  input  logic [NR_WRITE-1:0]      wr_clr_i,
  input  logic                     alloc_en_i,
  input  logic [AW-1:0]            alloc_addr_i,
  output logic [NREGS-1:0]         busy_vec_o
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  // Ports are walked in ascending order so the highest-index port has the last word;
  // a non-clearing winner restores the registered bit, overriding a lower port's clear.
  always_comb begin
    busy_next = busy_reg;
    for (int j = 0; j < NR_WRITE; j++) begin
      if (wr_en_i[j]) begin
        busy_next[wr_addr_i[j*AW +: AW]] = wr_clr_i[j] ? 1'b0 : busy_reg[wr_addr_i[j*AW +: AW]];
      end
    end
    if (alloc_en_i) begin
      busy_next[alloc_addr_i] = 1'b1;
    end
    if (ZR) begin
      busy_next[0] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy_reg <= '0;
    end else begin
      for (int j = 0; j < NR_WRITE; j++) begin
        if (wr_en_i[j] && !(ZR && wr_addr_i[j*AW +: AW] == '0)) begin
          regs[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
        end
      end
      busy_reg <= busy_next;
    end
  end

  assign busy_vec_o = busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NR_READ; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic          is_zero;
      assign addr    = rd_addr_i[gi*AW +: AW];
      assign is_zero = ZR && (addr == '0);
`ifdef REGFILE_BYPASS_EN
      logic            hit;
      logic            hit_clr;
      logic [XLEN-1:0] hit_data;
      always_comb begin
        hit      = 1'b0;
        hit_clr  = 1'b0;
        hit_data = '0;
        for (int j = 0; j < NR_WRITE; j++) begin
          if (wr_en_i[j] && wr_addr_i[j*AW +: AW] == addr) begin
            hit      = 1'b1;
            hit_clr  = wr_clr_i[j];
            hit_data = wr_data_i[j*XLEN +: XLEN];
          end
        end
      end
      assign rd_data_o[gi*XLEN +: XLEN] = is_zero ? '0 : (hit ? hit_data : regs[addr]);
      assign rd_busy_o[gi] = is_zero ? 1'b0 :
                             (hit && hit_clr && !(alloc_en_i && alloc_addr_i == addr)) ? 1'b0 :
                             busy_reg[addr];
`else
      assign rd_data_o[gi*XLEN +: XLEN] = is_zero ? '0 : regs[addr];
      assign rd_busy_o[gi] = is_zero ? 1'b0 : busy_reg[addr];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: array-based reference model compared every cycle,
// plus directed steps with literal expectations.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int NRD = 3;
  localparam int NWR = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NRD*AW-1:0]    rd_addr_i;
  logic [NRD*XLEN-1:0]  rd_data_o;
  logic [NRD-1:0]       rd_busy_o;
  logic [NWR-1:0]       wr_en_i;
  logic [NWR*AW-1:0]    wr_addr_i;
  logic [NWR*XLEN-1:0]  wr_data_i;
  logic [NWR-1:0]       wr_clr_i;
  logic                 alloc_en_i;
  logic [AW-1:0]        alloc_addr_i;
  logic [NREGS-1:0]     busy_vec_o;

  int tests = 0;
  int fails = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NR_READ(NRD), .NR_WRITE(NWR), .ZERO_REG(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .rd_busy_o(rd_busy_o), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_clr_i(wr_clr_i), .alloc_en_i(alloc_en_i), .alloc_addr_i(alloc_addr_i),
    .busy_vec_o(busy_vec_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural contents and busy flags as plain arrays.
  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_busy [NREGS];
  logic            m_valid = 1'b0;

  // Highest-index enabled write port targeting register r, or -1.
  function automatic int winner_of(input int r);
    int w = -1;
    for (int j = 0; j < NWR; j++)
      if (wr_en_i[j] && int'(wr_addr_i[j*AW +: AW]) == r) w = j;
    return w;
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] <= '0;
        m_busy[r] <= 1'b0;
      end
      m_valid <= 1'b1;
    end else if (m_valid) begin
      for (int r = 1; r < NREGS; r++) begin
        if (winner_of(r) >= 0) m_regs[r] <= wr_data_i[winner_of(r)*XLEN +: XLEN];
        if (alloc_en_i && int'(alloc_addr_i) == r) m_busy[r] <= 1'b1;
        else if (winner_of(r) >= 0 && wr_clr_i[winner_of(r)]) m_busy[r] <= 1'b0;
      end
    end
  end

  function automatic logic [XLEN-1:0] exp_data(input int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (winner_of(a) >= 0) return wr_data_i[winner_of(a)*XLEN +: XLEN];
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (winner_of(a) >= 0 && wr_clr_i[winner_of(a)] && !(alloc_en_i && int'(alloc_addr_i) == a))
      return 1'b0;
`endif
    return m_busy[a];
  endfunction

  always @(negedge clk_i) begin
    if (m_valid) begin
      logic [NREGS-1:0] ev;
      for (int r = 0; r < NREGS; r++) ev[r] = m_busy[r];
      check("busy_vec", 64'(busy_vec_o), 64'(ev));
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("rd_data[%0d]", k), 64'(rd_data_o[k*XLEN +: XLEN]),
              64'(exp_data(int'(rd_addr_i[k*AW +: AW]))));
        check($sformatf("rd_busy[%0d]", k), 64'(rd_busy_o[k]),
              64'(exp_busy(int'(rd_addr_i[k*AW +: AW]))));
      end
    end
  end

  task automatic idle();
    wr_en_i = '0; wr_addr_i = '0; wr_data_i = '0; wr_clr_i = '0;
    alloc_en_i = 1'b0; alloc_addr_i = '0;
  endtask

  task automatic set_wr(input int j, input int a, input logic [XLEN-1:0] d, input logic clr);
    wr_en_i[j] = 1'b1;
    wr_addr_i[j*AW +: AW] = AW'(a);
    wr_data_i[j*XLEN +: XLEN] = d;
    wr_clr_i[j] = clr;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr_i = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [XLEN-1:0] rd0();
    return rd_data_o[0 +: XLEN];
  endfunction

  initial begin
    rst_i = 1'b1;
    idle();
    set_rd(5, 0, 7);
    set_wr(0, 5, 32'hDEADBEEF, 1'b1);
    alloc_en_i = 1'b1; alloc_addr_i = 5'd5;
    step(); step();
    rst_i = 1'b0;
    idle();
    @(negedge clk_i);
    $display("[TB] reset with concurrent write to x5");
    check("reset_x5", 64'(rd0()), 64'h0);
    check("reset_busy", 64'(busy_vec_o), 64'h0);

    step();
    set_rd(7, 7, 0);
    set_wr(0, 7, 32'h12345678, 1'b0);
    @(negedge clk_i);
    $display("[TB] write x7 = 12345678");
`ifdef REGFILE_BYPASS_EN
    check("x7_same_cycle", 64'(rd0()), 64'h12345678);
`else
    check("x7_same_cycle", 64'(rd0()), 64'h0);
`endif
    step();
    idle();
    @(negedge clk_i);
    check("x7_next_cycle", 64'(rd0()), 64'h12345678);

    step();
    set_rd(0, 7, 0);
    set_wr(0, 0, 32'hFFFFFFFF, 1'b0);
    alloc_en_i = 1'b1; alloc_addr_i = 5'd0;
    $display("[TB] write and alloc x0");
    step();
    idle();
    @(negedge clk_i);
    check("x0_data", 64'(rd0()), 64'h0);
    check("x0_busy", 64'(busy_vec_o[0]), 64'h0);

    step();
    set_rd(9, 0, 0);
    set_wr(0, 9, 32'hAAAA0000, 1'b0);
    set_wr(1, 9, 32'h0000BBBB, 1'b0);
    $display("[TB] dual write conflict on x9");
    step();
    idle();
    @(negedge clk_i);
    check("x9_conflict", 64'(rd0()), 64'h0000BBBB);

    set_rd(3, 9, 7);
    alloc_en_i = 1'b1; alloc_addr_i = 5'd3;
    $display("[TB] alloc x3");
    step();
    idle();
    @(negedge clk_i);
    check("x3_alloc", 64'(busy_vec_o[3]), 64'h1);
    check("x3_rd_busy", 64'(rd_busy_o[0]), 64'h1);
    set_wr(1, 3, 32'h33, 1'b1);
    $display("[TB] writeback x3 with clear");
    step();
    idle();
    @(negedge clk_i);
    check("x3_cleared", 64'(busy_vec_o[3]), 64'h0);
    check("x3_value", 64'(rd0()), 64'h33);
    set_wr(0, 3, 32'h34, 1'b1);
    alloc_en_i = 1'b1; alloc_addr_i = 5'd3;
    $display("[TB] alloc and clear x3 together");
    step();
    idle();
    @(negedge clk_i);
    check("x3_alloc_wins", 64'(busy_vec_o[3]), 64'h1);
    set_wr(0, 3, 32'h35, 1'b0);
    $display("[TB] non-clearing writeback x3");
    step();
    idle();
    @(negedge clk_i);
    check("x3_still_busy", 64'(busy_vec_o[3]), 64'h1);
    check("x3_spec_data", 64'(rd0()), 64'h35);

    set_rd(4, 3, 9);
    alloc_en_i = 1'b1; alloc_addr_i = 5'd4;
    set_wr(0, 4, 32'h55, 1'b0);
    $display("[TB] alloc x4 and write 55");
    step();
    idle();
    @(negedge clk_i);
    check("x4_value", 64'(rd0()), 64'h55);
    check("x4_busy", 64'(busy_vec_o[4]), 64'h1);
    rst_i = 1'b1;
    set_wr(1, 4, 32'h99, 1'b1);
    $display("[TB] reset with clearing writeback of x4");
    step();
    rst_i = 1'b0;
    idle();
    @(negedge clk_i);
    check("x4_after_reset", 64'(rd0()), 64'h0);
    check("busy_after_reset", 64'(busy_vec_o), 64'h0);

    for (int i = 1; i <= 14; i++) begin
      step();
      set_rd(i, i - 1, (i + 5) % 32);
      set_wr(0, i, XLEN'(i) * 32'h01010101, 1'(i % 2));
      set_wr(1, (i + 5) % 32, ~(XLEN'(i) * 32'h00100401), 1'(i % 3 == 0));
      alloc_en_i = 1'(i % 4 != 0);
      alloc_addr_i = AW'((i * 3) % 32);
      $display("[TB] mixed cycle %0d", i);
    end
    step();
    idle();
    for (int i = 0; i < 11; i++) begin
      set_rd(3 * i % 32, (3 * i + 1) % 32, (3 * i + 2) % 32);
      step();
    end
    @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
